// File: rtl/serial_pattern_ctrl_pkg.sv
// Shared types and reset defaults for the serial pattern controller.
package serial_pattern_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int                LEN_W           = 4;
    localparam logic [7:0]        DEFAULT_PATTERN = 8'b110;
    localparam logic [LEN_W-1:0]  DEFAULT_LEN     = 4'd3;

endpackage

// File: rtl/serial_pattern_ctrl_if.sv
// Byte-stream valid/ready link from the requester into the controller.
interface serial_pattern_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_pattern_ctrl_pattern_match.sv
// Bit history, fill tracking and length-masked compare; hit reflects the bit consumed this cycle.
module pattern_match
    import serial_pattern_pkg::*;
#(
    parameter int MAX_PAT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_in,
    input  logic               bit_en,
    input  logic               clear,
    input  logic [MAX_PAT-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_PAT-1:0] hist;
    logic [MAX_PAT-1:0] hist_next;
    logic [MAX_PAT-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;

    // hit is evaluated on the post-shift history so the caller can register it on the same edge
    always_comb begin
        hist_next = {hist[MAX_PAT-2:0], bit_in};
        fill_next = (fill == LEN_W'(MAX_PAT)) ? fill : fill + LEN_W'(1);
        mask      = '0;
        for (int i = 0; i < MAX_PAT; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = bit_en && (len != '0) && (fill_next >= len) &&
              (((hist_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_en) begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

endmodule

// File: rtl/serial_pattern_ctrl.sv
// Byte serialiser feeding an overlapping pattern matcher, with config registers and match counter.
//   state | meaning
//   IDLE  | waiting for a byte, accepts config writes
//   SHIFT | consuming one bit per clock, MSB first
module serial_pattern_ctrl
    import serial_pattern_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_PAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_pattern_ctrl_if.slave in_bus,
    input  logic                 cfg_we,
    input  logic [MAX_PAT-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 count_clr,
    output logic                 busy,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic                 cfg_err
);

    localparam int BCNT_W = $clog2(DATA_W + 1);

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic [BCNT_W-1:0]  bit_cnt;
    logic [MAX_PAT-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               handshake;
    logic               cfg_ok;
    logic               hit;

    assign busy             = (state == SHIFT);
    assign in_bus.in_ready  = (state == IDLE) || (bit_cnt == BCNT_W'(1));
    assign handshake        = in_bus.in_valid && in_bus.in_ready;
    assign cfg_ok           = cfg_we && !busy && !handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        shreg   <= in_bus.in_data;
                        bit_cnt <= BCNT_W'(DATA_W);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // a handshake is only possible on the last bit, giving a bubble-free reload
                    if (handshake) begin
                        shreg   <= in_bus.in_data;
                        bit_cnt <= BCNT_W'(DATA_W);
                    end else begin
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - BCNT_W'(1);
                        if (bit_cnt == BCNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q   <= MAX_PAT'(DEFAULT_PATTERN);
            len_q       <= DEFAULT_LEN;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= (cfg_len > LEN_W'(MAX_PAT)) ? LEN_W'(MAX_PAT) : cfg_len;
            end
            if (count_clr || cfg_ok) begin
                match_count <= '0;
            end else if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    pattern_match #(
        .MAX_PAT (MAX_PAT)
    ) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (shreg[DATA_W-1]),
        .bit_en  (busy),
        .clear   (cfg_ok),
        .pattern (pattern_q),
        .len     (len_q),
        .hit     (hit)
    );

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Directed and randomized bench for serial_pattern_ctrl against a bit-stream reference model.
module tb_serial_pattern_ctrl;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       count_clr;
    logic       busy;
    logic       match;
    logic [CNT_W-1:0] match_count;
    logic       cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_pat;
    int         m_len;
    int         m_cnt;
    bit         hist[$];
    logic [7:0] txq[$];

    serial_pattern_ctrl_if #(.DATA_W(8)) bus ();

    serial_pattern_ctrl #(.DATA_W(8), .MAX_PAT(8), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bus      (bus),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .count_clr   (count_clr),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'b110;
        m_len = 3;
        m_cnt = 0;
        hist.delete();
    endtask

    // Match rule: the last len bits of the stream equal pattern, newest bit against pattern[0].
    task automatic consume(input bit b, output bit m);
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        m = 1'b0;
        if (m_len != 0 && hist.size() >= m_len) begin
            m = 1'b1;
            for (int j = 0; j < m_len; j++)
                if (hist[hist.size()-1-j] != m_pat[j]) m = 1'b0;
        end
    endtask

    task automatic cfg_write(input logic [7:0] p, input int l);
        bus.in_valid = 1'b0;
        cfg_we       = 1'b1;
        cfg_pattern  = p;
        cfg_len      = 4'(l);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_pat  = p;
        m_len  = (l > 8) ? 8 : l;
        m_cnt  = 0;
        hist.delete();
        check("cfg_ok_err", {15'd0, cfg_err}, 16'd0);
        check("cfg_ok_cnt", 16'(match_count), 16'd0);
    endtask

    // Streams txq back-to-back; clr_bit / cfg_cyc / abort_bits of -1 disable that feature.
    task automatic stream(input int clr_bit, input int cfg_cyc, input int abort_bits);
        int idx = 0, rem = 0, consumed = 0, cyc = 0;
        logic [7:0] cur = '0;
        bit hs, m, exp_err, cfg_now, aborted;
        aborted = 1'b0;
        while (idx < txq.size() || rem > 0) begin
            bus.in_valid = (idx < txq.size());
            bus.in_data  = (idx < txq.size()) ? txq[idx] : 8'h00;
            count_clr    = (rem > 0) && (consumed == clr_bit);
            cfg_now      = (cyc == cfg_cyc);
            cfg_we       = cfg_now;
            cfg_pattern  = 8'hA5;
            cfg_len      = 4'd8;
            check("in_ready", {15'd0, bus.in_ready}, {15'd0, (rem <= 1)});
            check("busy", {15'd0, busy}, {15'd0, (rem > 0)});
            hs = bus.in_valid && (rem <= 1);
            @(posedge clk); #1;
            exp_err = cfg_now && ((rem > 0) || hs);
            m = 1'b0;
            if (rem > 0) begin
                consume(cur[rem-1], m);
                rem--;
                consumed++;
            end
            if (count_clr) m_cnt = 0;
            else if (m && m_cnt < CNT_MAX) m_cnt++;
            if (hs) begin
                cur = txq[idx];
                idx++;
                rem = 8;
            end
            check("match", {15'd0, match}, {15'd0, m});
            check("match_count", 16'(match_count), 16'(m_cnt));
            check("cfg_err", {15'd0, cfg_err}, {15'd0, exp_err});
            cyc++;
            if (abort_bits >= 0 && consumed == abort_bits) begin
                aborted = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        count_clr    = 1'b0;
        cfg_we       = 1'b0;
        if (!aborted) check("busy_end", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        cfg_we       = 1'b0;
        cfg_pattern  = 8'h00;
        cfg_len      = 4'd0;
        count_clr    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {15'd0, bus.in_ready}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_match", {15'd0, match}, 16'd0);
        check("rst_cnt", 16'(match_count), 16'd0);
        check("rst_err", {15'd0, cfg_err}, 16'd0);

        // default 110 detector on 1101_1000
        txq = {8'hD8};
        stream(-1, -1, -1);
        check("d8_cnt", 16'(match_count), 16'd2);

        // cross-byte match across a back-to-back boundary
        cfg_write(8'b110, 3);
        txq = {8'h01, 8'h80};
        stream(-1, -1, -1);
        check("b2b_cnt", 16'(match_count), 16'd1);

        // config write while shifting is rejected
        cfg_write(8'b110, 3);
        txq = {8'hD8};
        stream(-1, 3, -1);
        check("rej_cnt", 16'(match_count), 16'd2);

        cfg_write(8'hA5, 8);
        txq = {8'hA5};
        stream(-1, -1, -1);
        check("a5_cnt", 16'(match_count), 16'd1);

        // saturation, with a config write coincident with the first handshake
        cfg_write(8'b110, 3);
        txq = {8'hD8, 8'hD8, 8'hD8};
        stream(-1, 0, -1);
        check("sat_cnt", 16'(match_count), 16'd3);
        txq = {8'hD8};
        stream(2, -1, -1);
        check("clr_cnt", 16'(match_count), 16'd1);

        cfg_write(8'b110, 0);
        txq = {8'hD8};
        stream(-1, -1, -1);
        check("len0_cnt", 16'(match_count), 16'd0);

        cfg_write(8'hD8, 12);
        txq = {8'hD8};
        stream(-1, -1, -1);
        check("len12_cnt", 16'(match_count), 16'd1);

        // reset in the middle of a byte, with a non-default detector loaded
        cfg_write(8'b1000, 4);
        txq = {8'hD8};
        stream(-1, -1, 4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {15'd0, bus.in_ready}, 16'd1);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_match", {15'd0, match}, 16'd0);
        check("mid_rst_cnt", 16'(match_count), 16'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        txq = {8'hD8};
        stream(-1, -1, -1);
        check("post_rst_cnt", 16'(match_count), 16'd2);

        // randomized configurations and streams with idle gaps
        for (int it = 0; it < 25; it++) begin
            cfg_write(8'($urandom), int'($urandom_range(0, 10)));
            n = int'($urandom_range(1, 4));
            txq.delete();
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
            stream(int'($urandom_range(0, 8 * n + 8)), -1, -1);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(posedge clk); #1;
                check("gap_match", {15'd0, match}, 16'd0);
            end
            n = int'($urandom_range(1, 3));
            txq.delete();
            for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
            stream(-1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_pattern_ctrl.md
# serial_pattern_ctrl

Sequencing controller for the serial sequence-detector datapath. It accepts parallel bytes from a requester over a valid/ready handshake and shifts them MSB-first, one bit per clock, into a programmable overlapping pattern matcher. It emits a one-cycle match pulse and keeps a saturating match count. It sits between a byte-wide producer and the bit-serial detection logic, and owns the detector's configuration (pattern, length).

## Interface
- DATA_W, 8, byte width shifted per transfer
- MAX_PAT, 8, maximum pattern length in bits
- CNT_W, 8, width of match counter
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  requester has a byte
- in_ready  output  1  controller can accept a byte this cycle
- in_data  input  DATA_W  byte to serialise, MSB first
- cfg_we  input  1  configuration write strobe
- cfg_pattern  input  MAX_PAT  pattern; bit [len-1] is compared with the oldest bit and bit 0 with the newest
- cfg_len  input  4  pattern length, 0..MAX_PAT
- count_clr  input  1  synchronous clear of match_count
- busy  output  1  shifting in progress
- match  output  1  one-cycle pulse: pattern completed by the last consumed bit
- match_count  output  CNT_W  saturating number of matches
- cfg_err  output  1  one-cycle pulse: cfg_we rejected

## Operation
- FSM states:
  - IDLE: in_ready=1, busy=0. Handshake (in_valid & in_ready) loads in_data into the shift register, loads the bit counter with DATA_W, and moves to SHIFT.
  - SHIFT: busy=1. Each cycle consumes the MSB into history and decrements the counter. in_ready=1 only when counter==1, i.e. the last bit.
  - Handshake on the last bit reloads and stays in SHIFT; otherwise the FSM returns to IDLE.
- History: MAX_PAT-bit shift register plus a fill counter (saturates at MAX_PAT). History persists across bytes and across IDLE gaps.
- Compare: hist[len-1:0] == pattern[len-1:0], qualified by fill >= len and len != 0. Overlapping matches count; there is no reset of history after a match.
- Config write:
  - Accepted only when busy=0 and no handshake occurs that cycle. It loads pattern and len, clears history, fill and match_count.
  - cfg_len > MAX_PAT saturates to MAX_PAT. len=0 disables matching.
  - cfg_we while busy, or coincident with a handshake, is ignored and pulses cfg_err the next cycle.
- match_count increments on each match and saturates at all-ones. If count_clr and a match land on the same edge, clear wins; the match pulse is still emitted.
- Reset (asynchronous, any state, including mid-byte):
  - State IDLE; current byte discarded.
  - match=0, match_count=0, cfg_err=0, busy=0, in_ready=1 after deassertion.
  - History and fill = 0.
  - Pattern = 'b110, len = 3 (default three-bit detector).

## Timing
- Byte accepted at edge A; its bit i (i=0 is the MSB) is consumed at edge A+1+i. The last bit is consumed at A+DATA_W.
- Back-to-back: next byte accepted at edge A+DATA_W, so the stream runs at one bit per clock with no bubble.
- match is registered: high for the cycle following the edge that consumed the completing bit. match_count updates on that same edge.
- in_ready, busy: combinational from state and counter only; no dependence on in_valid.
- cfg_err: registered, one cycle after the rejected cfg_we.

## Structure
- Package serial_pattern_pkg:
  - FSM state enum (IDLE, SHIFT).
  - Default pattern/length constants ('b110, 3).
  - cfg_len width constant.
- Sub-module pattern_match holds the history register, fill counter and comparator. Inputs: bit, bit_en, clear, pattern, len. Output: hit.
- The top holds the FSM, serialiser, config registers and counter.

## Test plan
- Reset defaults, then byte 0xD8 (1101_1000) → match high in cycles after edges A+3 and A+6, match_count=2, busy low after A+8.
- Bytes 0x01 then 0x80, sent back-to-back → in_ready high on the last bit of the first byte, no gap between bytes, exactly one match (cross-byte 1,1,0) after the 2nd bit of 0x80, count=1.
- cfg_we during SHIFT with pattern 0xA5, len 8 → cfg_err pulse, pattern unchanged (0xD8 still gives count 2). Then cfg_we in IDLE followed by byte 0xA5 → single match after the 8th bit, count=1 (config cleared it).
- CNT_W=2: three 0xD8 bytes (6 matches) → count saturates at 3. Then count_clr asserted on the same edge as a match → count=0 and match still pulses.
- Reset asserted mid-byte (after 4 bits) → outputs to reset values immediately, in_ready=1. The next byte 0xD8 yields count=2 with no stale history match.
- cfg_len=0 → no matches for 0xD8. cfg_len=12 → treated as 8.
